program_sequencer: RTL and testbench
====================================

Name: program_sequencer

Overview:
- Instruction-fetch and control-flow sequencer for the cellular multiprocessor array.
- On each frame_start it runs a program from address START_PC and fetches 16-bit words from a synchronous instruction ROM.
- It broadcasts each word to the array with a one-cycle execution_enable pulse, resolving jumps, divergence branches and call/return on a private return stack.
- It stops on HALT or a stack fault.

Parameters:
- PC_LENGTH, 12, program-counter and ROM address width.
- SP_LENGTH, 5, return-stack pointer width; stack depth 2**SP_LENGTH entries of PC_LENGTH bits.
- START_PC, 0, entry address loaded on frame_start.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- frame_start  in  1  single-cycle pulse; starts a program run.
- imem_addr  out  PC_LENGTH  ROM address; rdata valid one cycle later.
- imem_rdata  in  16  ROM read data.
- instruction  out  16  registered word broadcast to the array.
- execution_enable  out  1  array commit strobe.
- next_program_counter  out  PC_LENGTH  PC value after the current instruction.
- next_stack_pointer  out  SP_LENGTH  SP value after the current instruction.
- diverge_consensus  in  1  AND of all cell diverge flags; combinational from instruction.
- busy  out  1  high from run start until IDLE or HALTED.
- fault  out  1  sticky stack over/underflow flag.
- overrun_count  out  8  saturating count of frame_start pulses ignored while busy.

Behaviour:
- Reset values:
  - state=IDLE, pc=START_PC, sp=0.
  - instruction=16'h0000, execution_enable=0, busy=0, fault=0, overrun_count=0.
  - imem_addr=START_PC.
- States are IDLE, FETCH, EXEC, HALTED.
- IDLE:
  - frame_start: pc<=START_PC, sp<=0, fault<=0, then go to FETCH.
- FETCH (1 cycle):
  - imem_addr=pc.
  - Next edge: instruction<=imem_rdata, go to EXEC.
- EXEC (1 cycle):
  - Decode on opcode = instruction[15:12], target T = zero-extended instruction[11:0] truncated to PC_LENGTH.
  - 4'hA HALT: no enable; go to HALTED.
  - 4'hB RET:
    - sp==0: fault<=1, go to HALTED, no enable.
    - Otherwise: sp-1, pc<=stack[sp-1].
  - 4'hC CALL:
    - sp==2**SP_LENGTH-1: fault<=1, go to HALTED, no enable.
    - Otherwise: stack[sp]<=pc+1, sp+1, pc<=T.
  - 4'hD BRDIV: pc<=T if diverge_consensus is sampled high this cycle, else pc+1.
  - 4'hE JMP: pc<=T.
  - Any other opcode is a cell instruction: pc<=pc+1.
  - pc+1 wraps modulo 2**PC_LENGTH; no fault on wrap.
  - execution_enable=1 for exactly this cycle on every non-HALT, non-faulting instruction.
  - next_program_counter and next_stack_pointer carry the values pc and sp take at the next edge; they are valid whenever execution_enable=1.
  - Go to FETCH after a non-halting instruction.
  - Throughput is 2 cycles per instruction.
- HALTED:
  - Hold instruction, enable low.
  - The next frame_start behaves as in IDLE. IDLE and HALTED differ only in observability; HALTED is entered from run end.
- busy=1 in FETCH and EXEC.
- frame_start while busy:
  - Ignored.
  - overrun_count increments, saturating at 255.
- frame_start in the same cycle as entry to HALTED is ignored, not counted.
- Async reset mid-run: all outputs drop to reset values immediately; execution_enable never glitches high during reset.
- The stack is a register array; its contents are undefined after reset and are never read before being written.

Optional Feature:
- Macro SEQ_INSTR_COUNTER_EN.
- Defined:
  - Adds output instr_count (16 bits), reset to 0.
  - Cleared on each accepted frame_start.
  - Increments, saturating, on every execution_enable pulse.
- Undefined: no port and no counter logic; all other behaviour is identical.

Test Plan:
- ROM [0]=16'h1234, [1]=16'h5678, [2]=16'hA000; pulse frame_start -> exactly 2 execution_enable pulses with instruction 16'h1234 then 16'h5678 and next_program_counter 1 then 2; busy falls 1 cycle after HALT is in EXEC.
- [0]=16'hC005 CALL, [5]=16'h1111, [6]=16'hB000 RET, [1]=16'hA000 -> enables carry next_stack_pointer 1,1,0 and next_program_counter 5,6,1; then halt with fault=0.
- [0]=16'hD010 with diverge_consensus=1 -> next PC 16'h010; with diverge_consensus=0 -> next PC 1.
- [0]=16'hB000 RET at sp=0 -> fault=1, no enable, HALTED; a further frame_start clears fault and restarts at START_PC.
- 32 nested CALLs with SP_LENGTH=5 -> the 32nd faults and sp stays 31; three frame_start pulses during a run -> overrun_count=3; assert rst while in EXEC -> execution_enable=0 and busy=0 before the next clock edge.

Source files
------------

// File: rtl/program_sequencer_if.sv
// Bus bundle between the program sequencer, its instruction ROM and the cell array.
// Optional signal instr_count exists only when SEQ_INSTR_COUNTER_EN is defined.
//
// Handshake: there is no back-pressure. execution_enable is a one-cycle commit
// strobe; instruction, next_program_counter and next_stack_pointer are valid
// only while it is high, and the array must consume them in that cycle.
// imem_addr is a plain read address, and imem_rdata returns one cycle later.
interface program_sequencer_if #(
    parameter int PC_LENGTH = 12,
    parameter int SP_LENGTH = 5
);
    logic                 frame_start;
    logic [PC_LENGTH-1:0] imem_addr;
    logic [15:0]          imem_rdata;
    logic [15:0]          instruction;
    logic                 execution_enable;
    logic [PC_LENGTH-1:0] next_program_counter;
    logic [SP_LENGTH-1:0] next_stack_pointer;
    logic                 diverge_consensus;
    logic                 busy;
    logic                 fault;
    logic [7:0]           overrun_count;
    logic [1:0]           state;          // debug view of the sequencer FSM
`ifdef SEQ_INSTR_COUNTER_EN
    logic [15:0]          instr_count;
`endif

    // Sequencer side
    modport master (
        input  frame_start, imem_rdata, diverge_consensus,
`ifdef SEQ_INSTR_COUNTER_EN
        output instr_count,
`endif
        output imem_addr, instruction, execution_enable, next_program_counter,
        output next_stack_pointer, busy, fault, overrun_count, state
    );

    // ROM / array / controller side
    modport slave (
        output frame_start, imem_rdata, diverge_consensus,
`ifdef SEQ_INSTR_COUNTER_EN
        input  instr_count,
`endif
        input  imem_addr, instruction, execution_enable, next_program_counter,
        input  next_stack_pointer, busy, fault, overrun_count, state
    );
endinterface

// File: rtl/program_sequencer.sv
// Instruction-fetch / control-flow sequencer for the cellular array.
// Fetches 16-bit words from a synchronous ROM, broadcasts them with a one-cycle
// execution_enable, and resolves JMP / BRDIV / CALL / RET on a private stack.
// Optional feature macro: SEQ_INSTR_COUNTER_EN (adds the instr_count output).
module program_sequencer #(
    parameter int                   PC_LENGTH = 12,
    parameter int                   SP_LENGTH = 5,
    parameter logic [PC_LENGTH-1:0] START_PC  = '0
) (
    input logic                  clk,
    input logic                  rst,
    program_sequencer_if.master  bus
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_FETCH  = 2'd1;
    localparam logic [1:0] S_EXEC   = 2'd2;
    localparam logic [1:0] S_HALTED = 2'd3;

    localparam logic [3:0] OP_HALT  = 4'hA;
    localparam logic [3:0] OP_RET   = 4'hB;
    localparam logic [3:0] OP_CALL  = 4'hC;
    localparam logic [3:0] OP_BRDIV = 4'hD;
    localparam logic [3:0] OP_JMP   = 4'hE;

    logic [1:0]           state, state_d;
    logic [PC_LENGTH-1:0] pc, pc_d, pc_inc, target;
    logic [SP_LENGTH-1:0] sp, sp_d, sp_dec;
    logic                 fault_q, fault_d;
    logic [15:0]          instr_q;
    logic [7:0]           overrun_q;
    logic                 enable, halting, push;
    logic [3:0]           opcode;
    logic [PC_LENGTH-1:0] stack [2**SP_LENGTH];

    assign opcode = instr_q[15:12];
    assign target = PC_LENGTH'(instr_q[11:0]);
    assign pc_inc = pc + PC_LENGTH'(1);
    assign sp_dec = sp - SP_LENGTH'(1);

    // Next-state, next-PC/SP and fault decode for the whole FSM
    always_comb begin
        state_d = state;
        pc_d    = pc;
        sp_d    = sp;
        fault_d = fault_q;
        enable  = 1'b0;
        halting = 1'b0;
        push    = 1'b0;
        case (state)
            S_IDLE, S_HALTED: begin
                if (bus.frame_start) begin
                    pc_d    = START_PC;
                    sp_d    = '0;
                    fault_d = 1'b0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: state_d = S_EXEC;
            S_EXEC: begin
                enable = 1'b1;
                case (opcode)
                    OP_HALT: halting = 1'b1;
                    OP_RET: begin
                        if (sp == '0) begin
                            fault_d = 1'b1;
                            halting = 1'b1;
                        end else begin
                            sp_d = sp_dec;
                            pc_d = stack[sp_dec];
                        end
                    end
                    OP_CALL: begin
                        if (&sp) begin
                            fault_d = 1'b1;
                            halting = 1'b1;
                        end else begin
                            push = 1'b1;
                            sp_d = sp + SP_LENGTH'(1);
                            pc_d = target;
                        end
                    end
                    OP_BRDIV: pc_d = bus.diverge_consensus ? target : pc_inc;
                    OP_JMP:   pc_d = target;
                    default:  pc_d = pc_inc;
                endcase
                if (halting) begin
                    enable  = 1'b0;
                    state_d = S_HALTED;
                end else begin
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control registers: FSM, PC, SP, sticky fault, instruction and overrun counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            pc        <= START_PC;
            sp        <= '0;
            fault_q   <= 1'b0;
            instr_q   <= 16'h0000;
            overrun_q <= 8'd0;
        end else begin
            state   <= state_d;
            pc      <= pc_d;
            sp      <= sp_d;
            fault_q <= fault_d;
            if (state == S_FETCH) begin
                instr_q <= bus.imem_rdata;
            end
            // A start pulse during the halting EXEC cycle is dropped silently
            if (bus.frame_start && bus.busy && !halting && overrun_q != 8'hFF) begin
                overrun_q <= overrun_q + 8'd1;
            end
        end
    end

    // Return stack: written only by a successful CALL, never read before written
    always_ff @(posedge clk) begin
        if (push) begin
            stack[sp] <= pc_inc;
        end
    end

`ifdef SEQ_INSTR_COUNTER_EN
    logic [15:0] instr_cnt_q;

    // Saturating count of committed instructions in the current run
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_cnt_q <= 16'd0;
        end else if ((state == S_IDLE || state == S_HALTED) && bus.frame_start) begin
            instr_cnt_q <= 16'd0;
        end else if (enable && instr_cnt_q != 16'hFFFF) begin
            instr_cnt_q <= instr_cnt_q + 16'd1;
        end
    end

    assign bus.instr_count = instr_cnt_q;
`endif

    // The ROM is addressed with the upcoming PC so its data lands in FETCH
    assign bus.imem_addr            = pc_d;
    assign bus.instruction          = instr_q;
    assign bus.execution_enable     = enable;
    assign bus.next_program_counter = pc_d;
    assign bus.next_stack_pointer   = sp_d;
    assign bus.busy                 = (state == S_FETCH) || (state == S_EXEC);
    assign bus.fault                = fault_q;
    assign bus.overrun_count        = overrun_q;
    assign bus.state                = state;
endmodule

// File: tb/tb_program_sequencer.sv
// Self-checking bench for program_sequencer: table-driven single-instruction
// vectors, hand-written multi-cycle sequences, and a scoreboard of expected
// {instruction, next_pc, next_sp} entries checked on every execution_enable.
module tb_program_sequencer;
  localparam int W = 33;

  logic clk;
  logic rst;
  logic [15:0] rom [4096];
  logic [W-1:0] exp_q[$];
  int checks;
  int errors;

  program_sequencer_if #(.PC_LENGTH(12), .SP_LENGTH(5)) bus ();

  program_sequencer #(
    .PC_LENGTH(12),
    .SP_LENGTH(5),
    .START_PC (12'h000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [15:0] word;
    logic        div;
    logic        exp_en;
    logic [11:0] exp_npc;
    logic [4:0]  exp_nsp;
    logic        exp_fault;
  } vec_t;

  // clock and synchronous ROM model
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) bus.imem_rdata <= rom[bus.imem_addr];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboard: every enable pops one expected entry
  always @(negedge clk) begin
    if (!rst && bus.execution_enable) begin
      if (exp_q.size() == 0) begin
        check("unexpected_enable", 64'd1, 64'd0);
      end else begin
        check("enable_word",
              {31'd0, bus.instruction, bus.next_program_counter, bus.next_stack_pointer},
              {31'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic push_exp(input logic [15:0] w, input logic [11:0] npc, input logic [4:0] nsp);
    exp_q.push_back({w, npc, nsp});
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 4096; i++) rom[i] = 16'hA000;
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1 bus.frame_start = 1'b1;
    @(posedge clk);
    #1 bus.frame_start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (bus.busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("run_done", {63'd0, bus.busy}, 64'd0);
  endtask

  vec_t vecs[7];

  initial begin
    checks = 0;
    errors = 0;
    vecs[0] = '{16'h1234, 1'b0, 1'b1, 12'h001, 5'd0, 1'b0};
    vecs[1] = '{16'hD010, 1'b1, 1'b1, 12'h010, 5'd0, 1'b0};
    vecs[2] = '{16'hD010, 1'b0, 1'b1, 12'h001, 5'd0, 1'b0};
    vecs[3] = '{16'hE020, 1'b0, 1'b1, 12'h020, 5'd0, 1'b0};
    vecs[4] = '{16'hC005, 1'b0, 1'b1, 12'h005, 5'd1, 1'b0};
    vecs[5] = '{16'hB000, 1'b0, 1'b0, 12'h000, 5'd0, 1'b1};
    vecs[6] = '{16'hA000, 1'b0, 1'b0, 12'h000, 5'd0, 1'b0};

    rst = 1'b1;
    bus.frame_start = 1'b0;
    bus.diverge_consensus = 1'b0;
    clear_rom();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // reset state
    @(negedge clk);
    check("rst_state", {62'd0, bus.state}, 64'd0);
    check("rst_instruction", {48'd0, bus.instruction}, 64'd0);
    check("rst_enable", {63'd0, bus.execution_enable}, 64'd0);
    check("rst_busy", {63'd0, bus.busy}, 64'd0);
    check("rst_fault", {63'd0, bus.fault}, 64'd0);
    check("rst_overrun", {56'd0, bus.overrun_count}, 64'd0);
    check("rst_imem_addr", {52'd0, bus.imem_addr}, 64'd0);

    // two cell instructions then HALT, with busy timing and a start at halt entry
    clear_rom();
    rom[0] = 16'h1234; rom[1] = 16'h5678; rom[2] = 16'hA000;
    push_exp(16'h1234, 12'h001, 5'd0);
    push_exp(16'h5678, 12'h002, 5'd0);
    pulse_start();
    repeat (6) @(negedge clk);
    check("halt_exec_instr", {48'd0, bus.instruction}, 64'hA000);
    check("halt_exec_busy", {63'd0, bus.busy}, 64'd1);
    check("halt_exec_enable", {63'd0, bus.execution_enable}, 64'd0);
    bus.frame_start = 1'b1;
    @(posedge clk);
    #1 bus.frame_start = 1'b0;
    check("halt_busy_fall", {63'd0, bus.busy}, 64'd0);
    check("halt_entry_start_ignored", {56'd0, bus.overrun_count}, 64'd0);
    check("halted_hold_instr", {48'd0, bus.instruction}, 64'hA000);
    check("prog1_sb_empty", exp_q.size(), 64'd0);
`ifdef SEQ_INSTR_COUNTER_EN
    check("instr_count", {48'd0, bus.instr_count}, 64'd2);
`endif

    // CALL / RET
    clear_rom();
    rom[0] = 16'hC005; rom[5] = 16'h1111; rom[6] = 16'hB000; rom[1] = 16'hA000;
    push_exp(16'hC005, 12'h005, 5'd1);
    push_exp(16'h1111, 12'h006, 5'd1);
    push_exp(16'hB000, 12'h001, 5'd0);
    pulse_start();
    wait_done(50);
    check("call_ret_sb_empty", exp_q.size(), 64'd0);
    check("call_ret_fault", {63'd0, bus.fault}, 64'd0);

    // single-instruction decode table
    for (int k = 0; k < 7; k++) begin
      clear_rom();
      rom[0] = vecs[k].word;
      bus.diverge_consensus = vecs[k].div;
      if (vecs[k].exp_en) push_exp(vecs[k].word, vecs[k].exp_npc, vecs[k].exp_nsp);
      pulse_start();
      wait_done(50);
      check($sformatf("vec%0d_sb_empty", k), exp_q.size(), 64'd0);
      check($sformatf("vec%0d_fault", k), {63'd0, bus.fault}, {63'd0, vecs[k].exp_fault});
    end
    bus.diverge_consensus = 1'b0;

    // restart after the RET underflow fault clears fault and begins at START_PC
    check("fault_before_restart", {63'd0, bus.fault}, 64'd0);
    clear_rom();
    rom[0] = 16'hB000;
    pulse_start();
    wait_done(50);
    check("underflow_fault", {63'd0, bus.fault}, 64'd1);
    rom[0] = 16'h1234;
    push_exp(16'h1234, 12'h001, 5'd0);
    pulse_start();
    check("restart_fault_clear", {63'd0, bus.fault}, 64'd0);
    wait_done(50);
    check("restart_sb_empty", exp_q.size(), 64'd0);

    // 32 nested calls: the 32nd overflows
    clear_rom();
    for (int i = 0; i < 32; i++) rom[i] = 16'hC000 | 16'(i + 1);
    for (int i = 0; i < 31; i++) push_exp(16'hC000 | 16'(i + 1), 12'(i + 1), 5'(i + 1));
    pulse_start();
    wait_done(200);
    check("overflow_sb_empty", exp_q.size(), 64'd0);
    check("overflow_fault", {63'd0, bus.fault}, 64'd1);
    check("overflow_sp", {59'd0, bus.next_stack_pointer}, 64'd31);

    // long run: overruns, then async reset in EXEC
    clear_rom();
    for (int i = 0; i < 40; i++) begin
      rom[i] = 16'h0100 + 16'(i);
      push_exp(16'h0100 + 16'(i), 12'(i + 1), 5'd0);
    end
    pulse_start();
    for (int p = 0; p < 3; p++) begin
      repeat (3) @(posedge clk);
      #1 bus.frame_start = 1'b1;
      @(posedge clk);
      #1 bus.frame_start = 1'b0;
    end
    @(negedge clk);
    check("overrun_count", {56'd0, bus.overrun_count}, 64'd3);
    begin
      int n;
      n = 0;
      while (!bus.execution_enable && n < 10) begin
        @(negedge clk);
        n++;
      end
      check("found_exec", {63'd0, bus.execution_enable}, 64'd1);
    end
    #2 rst = 1'b1;
    #1;
    check("async_rst_enable", {63'd0, bus.execution_enable}, 64'd0);
    check("async_rst_busy", {63'd0, bus.busy}, 64'd0);
    check("async_rst_instr", {48'd0, bus.instruction}, 64'd0);
    check("async_rst_overrun", {56'd0, bus.overrun_count}, 64'd0);
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_idle", {62'd0, bus.state}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
